// File: rtl/osc_bank.sv
// osc_bank: multi-voice tone oscillator bank.
//
// Each voice has a period counter that runs 1..P (P = divider << octave_dn),
// a square-wave output that toggles on every terminal count, and a one-cycle
// terminal tick. New divider/octave values are double-buffered and take effect
// only on a period boundary, so a running voice never produces a short or
// glitched half-cycle.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   enable     per-voice run enable (level)
//   load       per-voice update strobe; samples that voice's divider/octave_dn slice
//   divider    packed per-voice divider, voice i at [i*DIV_W +: DIV_W]
//   octave_dn  packed per-voice octave-down shift, voice i at [i*OCT_W +: OCT_W]
//   count      packed per-voice counter value
//   period     packed per-voice active effective period
//   tick       per-voice terminal-count flag
//   wave       per-voice square wave
//   pending    per-voice "update queued, not yet applied"
//   mix        number of voices whose wave is high
module osc_bank #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 18,
    parameter int OCT_W      = 2,
    localparam int PER_W     = DIV_W + 2**OCT_W - 1,
    localparam int MIX_W     = $clog2(NUM_VOICES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_VOICES-1:0]       enable,
    input  logic [NUM_VOICES-1:0]       load,
    input  logic [NUM_VOICES*DIV_W-1:0] divider,
    input  logic [NUM_VOICES*OCT_W-1:0] octave_dn,
    output logic [NUM_VOICES*PER_W-1:0] count,
    output logic [NUM_VOICES*PER_W-1:0] period,
    output logic [NUM_VOICES-1:0]       tick,
    output logic [NUM_VOICES-1:0]       wave,
    output logic [NUM_VOICES-1:0]       pending,
    output logic [MIX_W-1:0]            mix
);

    // Per-voice state
    logic [PER_W-1:0]      cnt_q      [NUM_VOICES];
    logic [DIV_W-1:0]      act_div_q  [NUM_VOICES];
    logic [OCT_W-1:0]      act_oct_q  [NUM_VOICES];
    logic [DIV_W-1:0]      pend_div_q [NUM_VOICES];
    logic [OCT_W-1:0]      pend_oct_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] wav_q;
    logic [NUM_VOICES-1:0] pend_q;

    // Unpacked views of the inputs and derived per-voice values
    logic [DIV_W-1:0]      div_in  [NUM_VOICES];
    logic [OCT_W-1:0]      oct_in  [NUM_VOICES];
    logic [PER_W-1:0]      per_eff [NUM_VOICES];
    logic [NUM_VOICES-1:0] tick_c;

    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            div_in[i]  = divider[i*DIV_W +: DIV_W];
            oct_in[i]  = octave_dn[i*OCT_W +: OCT_W];
            // PER_W holds the largest possible shift, so no bits are lost.
            per_eff[i] = PER_W'(act_div_q[i]) << act_oct_q[i];
            tick_c[i]  = enable[i] && (per_eff[i] != '0) && (cnt_q[i] >= per_eff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                cnt_q[i]      <= '0;
                act_div_q[i]  <= '0;
                act_oct_q[i]  <= '0;
                pend_div_q[i] <= '0;
                pend_oct_q[i] <= '0;
            end
            wav_q  <= '0;
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (!enable[i] || (per_eff[i] == '0)) begin
                    // Idle or muted: no period is running, so updates need
                    // not wait for a boundary. A fresh load beats a queued one.
                    cnt_q[i] <= '0;
                    wav_q[i] <= 1'b0;
                    if (load[i]) begin
                        act_div_q[i] <= div_in[i];
                        act_oct_q[i] <= oct_in[i];
                        pend_q[i]    <= 1'b0;
                    end else if (pend_q[i]) begin
                        act_div_q[i] <= pend_div_q[i];
                        act_oct_q[i] <= pend_oct_q[i];
                        pend_q[i]    <= 1'b0;
                    end
                end else if (tick_c[i]) begin
                    // Period boundary: restart at 1 and swap in the new
                    // setting. A load on this very edge bypasses the buffer.
                    cnt_q[i] <= PER_W'(1);
                    wav_q[i] <= ~wav_q[i];
                    if (load[i]) begin
                        act_div_q[i] <= div_in[i];
                        act_oct_q[i] <= oct_in[i];
                        pend_q[i]    <= 1'b0;
                    end else if (pend_q[i]) begin
                        act_div_q[i] <= pend_div_q[i];
                        act_oct_q[i] <= pend_oct_q[i];
                        pend_q[i]    <= 1'b0;
                    end
                end else begin
                    cnt_q[i] <= cnt_q[i] + PER_W'(1);
                    if (load[i]) begin
                        pend_div_q[i] <= div_in[i];
                        pend_oct_q[i] <= oct_in[i];
                        pend_q[i]     <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        count  = '0;
        period = '0;
        mix    = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            count[i*PER_W +: PER_W]  = cnt_q[i];
            period[i*PER_W +: PER_W] = per_eff[i];
            mix = mix + MIX_W'(wav_q[i]);
        end
    end

    assign tick    = tick_c;
    assign wave    = wav_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: table-driven bench for osc_bank with a scoreboard queue.
// Voice 0 is exercised through a hand-derived vector table; the four-voice
// phase uses closed-form expectations derived from the cycle index.
module tb_osc_bank;

    localparam int NV = 4;
    localparam int DW = 18;
    localparam int OW = 2;
    localparam int PW = DW + 2**OW - 1;
    localparam int MW = $clog2(NV + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [NV-1:0]    enable;
    logic [NV-1:0]    load;
    logic [NV*DW-1:0] divider;
    logic [NV*OW-1:0] octave_dn;
    logic [NV*PW-1:0] count;
    logic [NV*PW-1:0] period;
    logic [NV-1:0]    tick;
    logic [NV-1:0]    wave;
    logic [NV-1:0]    pending;
    logic [MW-1:0]    mix;

    always #5 clk = ~clk;

    osc_bank #(.NUM_VOICES(NV), .DIV_W(DW), .OCT_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .divider   (divider),
        .octave_dn (octave_dn),
        .count     (count),
        .period    (period),
        .tick      (tick),
        .wave      (wave),
        .pending   (pending),
        .mix       (mix)
    );

    typedef struct {
        logic [NV*PW-1:0] cnt;
        logic [NV*PW-1:0] per;
        logic [NV-1:0]    tk;
        logic [NV-1:0]    wv;
        logic [NV-1:0]    pd;
        logic [MW-1:0]    mx;
        string            name;
    } exp_t;

    typedef struct {
        logic          r;
        logic          en0;
        logic          ld0;
        logic [DW-1:0] div0;
        logic [OW-1:0] oct0;
        logic [PW-1:0] cnt0;
        logic [PW-1:0] per0;
        logic          tk;
        logic          wv;
        logic          pd;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic add(input int unsigned r, en, ld, d, o, c, p, tk, wv, pd);
        vec_t v;
        v.r    = r[0];
        v.en0  = en[0];
        v.ld0  = ld[0];
        v.div0 = DW'(d);
        v.oct0 = OW'(o);
        v.cnt0 = PW'(c);
        v.per0 = PW'(p);
        v.tk   = tk[0];
        v.wv   = wv[0];
        v.pd   = pd[0];
        tbl.push_back(v);
    endtask

    task automatic cmp(input string name, input string what,
                       input logic [NV*PW-1:0] act, input logic [NV*PW-1:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", name, what, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: output with no expectation queued");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        cmp(e.name, "count",   count,                     e.cnt);
        cmp(e.name, "period",  period,                    e.per);
        cmp(e.name, "tick",    (NV*PW)'(tick),            (NV*PW)'(e.tk));
        cmp(e.name, "wave",    (NV*PW)'(wave),            (NV*PW)'(e.wv));
        cmp(e.name, "pending", (NV*PW)'(pending),         (NV*PW)'(e.pd));
        cmp(e.name, "mix",     (NV*PW)'(mix),             (NV*PW)'(e.mx));
    endtask

    task automatic step(input logic r, input logic [NV-1:0] en, ld,
                        input logic [NV*DW-1:0] d, input logic [NV*OW-1:0] o,
                        input exp_t e);
        rst       = r;
        enable    = en;
        load      = ld;
        divider   = d;
        octave_dn = o;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        exp_t e;
        // ---------------- voice 0 table: r en ld div oct | cnt per tick wave pend
        add(1,0,0,0,0,       0,0,0,0,0);   // reset
        add(0,0,1,3,0,       0,3,0,0,0);   // load while disabled applies at once
        add(0,1,0,0,0,       1,3,0,0,0);
        add(0,1,0,0,0,       2,3,0,0,0);
        add(0,1,0,0,0,       3,3,1,0,0);   // first tick: P+1 cycle first period
        add(0,1,0,0,0,       1,3,0,1,0);
        add(0,1,0,0,0,       2,3,0,1,0);
        add(0,1,0,0,0,       3,3,1,1,0);
        add(0,1,0,0,0,       1,3,0,0,0);
        add(0,1,1,5,0,       2,3,0,0,1);   // mid-period load queues
        add(0,1,0,0,0,       3,3,1,0,1);
        add(0,1,0,0,0,       1,5,0,1,0);   // applied at boundary
        add(0,1,1,6,0,       2,5,0,1,1);
        add(0,1,1,7,0,       3,5,0,1,1);   // last load wins
        add(0,1,0,0,0,       4,5,0,1,1);
        add(0,1,0,0,0,       5,5,1,1,1);
        add(0,1,0,0,0,       1,7,0,0,0);
        for (int c = 2; c <= 6; c++) add(0,1,0,0,0, c,7,0,0,0);
        add(0,1,0,0,0,       7,7,1,0,0);
        add(0,1,1,4,0,       1,4,0,1,0);   // load on terminal edge bypasses
        add(0,1,0,0,0,       2,4,0,1,0);
        add(0,1,0,0,0,       3,4,0,1,0);
        add(0,1,0,0,0,       4,4,1,1,0);
        add(0,1,0,0,0,       1,4,0,0,0);
        add(0,1,1,3,2,       2,4,0,0,1);   // octave shift queued
        add(0,1,0,0,0,       3,4,0,0,1);
        add(0,1,0,0,0,       4,4,1,0,1);
        add(0,1,0,0,0,       1,12,0,1,0);
        for (int c = 2; c <= 10; c++) add(0,1,0,0,0, c,12,0,1,0);
        add(0,1,1,2,0,       11,12,0,1,1);
        add(0,0,0,0,0,       0,2,0,0,0);   // disable mid-period: clear, apply pend
        add(0,0,0,0,0,       0,2,0,0,0);
        add(0,1,0,0,0,       1,2,0,0,0);   // restart from 0
        add(0,1,0,0,0,       2,2,1,0,0);
        add(0,1,0,0,0,       1,2,0,1,0);
        add(0,1,1,0,0,       2,2,1,1,1);   // queue divider 0
        add(0,1,0,0,0,       1,0,0,0,0);   // muted from here
        add(0,1,0,0,0,       0,0,0,0,0);
        add(0,1,0,0,0,       0,0,0,0,0);
        add(0,1,1,3,0,       0,3,0,0,0);   // load while muted applies at once
        add(0,1,0,0,0,       1,3,0,0,0);
        add(0,0,1,'h3FFFF,3, 0,'h1FFFF8,0,0,0); // max period, no wrap
        add(0,1,0,0,0,       1,'h1FFFF8,0,0,0);
        add(1,1,0,0,0,       0,0,0,0,0);   // reset mid-run

        foreach (tbl[i]) begin
            e.cnt  = (NV*PW)'(tbl[i].cnt0);
            e.per  = (NV*PW)'(tbl[i].per0);
            e.tk   = NV'(tbl[i].tk);
            e.wv   = NV'(tbl[i].wv);
            e.pd   = NV'(tbl[i].pd);
            e.mx   = MW'(tbl[i].wv);
            e.name = $sformatf("tbl[%0d]", i);
            step(tbl[i].r, NV'(tbl[i].en0), NV'(tbl[i].ld0),
                 (NV*DW)'(tbl[i].div0), (NV*OW)'(tbl[i].oct0), e);
        end

        // ---------------- four voices, dividers 2,3,4,5
        e.cnt  = '0;
        e.per  = {PW'(5), PW'(4), PW'(3), PW'(2)};
        e.tk   = '0;
        e.wv   = '0;
        e.pd   = '0;
        e.mx   = '0;
        e.name = "multi_load";
        step(1'b0, 4'h0, 4'hF, {DW'(5), DW'(4), DW'(3), DW'(2)}, '0, e);

        for (int k = 1; k <= 64; k++) begin
            int unsigned m;
            m = 0;
            for (int v = 0; v < NV; v++) begin
                int p, w;
                p = v + 2;
                w = ((k - 1) / p) % 2;
                e.cnt[v*PW +: PW] = PW'(((k - 1) % p) + 1);
                e.tk[v] = ((k % p) == 0);
                e.wv[v] = w[0];
                m += w;
            end
            e.mx   = MW'(m);
            e.name = $sformatf("multi_k%0d", k);
            step(1'b0, 4'hF, 4'h0, '0, '0, e);
        end

        e.cnt  = '0;
        e.per  = '0;
        e.tk   = '0;
        e.wv   = '0;
        e.pd   = '0;
        e.mx   = '0;
        e.name = "multi_reset";
        step(1'b1, 4'hF, 4'h0, '0, '0, e);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
